// File: rtl/psum_accumulator.sv
// Accumulates decompressed psum rows from the array output FIFO across all kernel
// positions of a layer, then drains one optionally ReLU'd row per handshake.
module psum_accumulator #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int NPIX    = 16,
    parameter int NKIJ    = 9,
    parameter int addr_bw = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     relu_en,
    input  logic                     fifo_rdy,
    output logic                     fifo_rd,
    input  logic [col*psum_bw-1:0]   fifo_dout,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [col*psum_bw-1:0]   out_data,
    output logic [addr_bw-1:0]       out_addr,
    output logic                     busy,
    output logic                     done
);

    localparam int TOTAL = NPIX * NKIJ;
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam int KIJ_W = (NKIJ > 1) ? $clog2(NKIJ + 1) : 1;
    localparam int ROW_W = col * psum_bw;

    localparam logic [psum_bw-1:0] PSUM_MAX = {1'b0, {(psum_bw-1){1'b1}}};
    localparam logic [psum_bw-1:0] PSUM_MIN = {1'b1, {(psum_bw-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_DRAIN, S_DONE} state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     rd_cnt, wr_cnt;
    logic [addr_bw-1:0]   wr_pix, drain_idx;
    logic [KIJ_W-1:0]     wr_kij;
    logic                 rd_vld;
    logic                 relu_q;
    logic [ROW_W-1:0]     acc [NPIX];
    logic [ROW_W-1:0]     wr_row;
    logic [ROW_W-1:0]     drain_row;

    logic start_acc;
    logic last_wr;
    logic drain_hs;
    logic last_drain;

    function automatic logic [psum_bw-1:0] sat_add(input logic [psum_bw-1:0] a,
                                                   input logic [psum_bw-1:0] b);
        logic [psum_bw:0] s;
        s = {a[psum_bw-1], a} + {b[psum_bw-1], b};
        if (s[psum_bw] != s[psum_bw-1])
            return s[psum_bw] ? PSUM_MIN : PSUM_MAX;
        return s[psum_bw-1:0];
    endfunction

    assign start_acc  = (state == S_IDLE) && start;
    assign last_wr    = rd_vld && (wr_cnt == CNT_W'(TOTAL - 1));
    assign drain_hs   = (state == S_DRAIN) && out_ready;
    assign last_drain = drain_hs && (drain_idx == addr_bw'(NPIX - 1));

    // NOTE: fifo_rd is combinational from state, so it is also gated by reset; otherwise
    // the cycle in which reset is sampled could still pop a row from the FIFO.
    assign fifo_rd = !reset && (state == S_ACC) && fifo_rdy && (rd_cnt < CNT_W'(TOTAL));

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start)      state_nxt = S_ACC;
            S_ACC:   if (last_wr)    state_nxt = S_DRAIN;
            S_DRAIN: if (last_drain) state_nxt = S_DONE;
            S_DONE:                  state_nxt = S_IDLE;
            default:                 state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        wr_row    = '0;
        drain_row = acc[drain_idx];
        for (int i = 0; i < col; i++) begin
            if (wr_kij == '0)
                wr_row[i*psum_bw +: psum_bw] = fifo_dout[i*psum_bw +: psum_bw];
            else
                wr_row[i*psum_bw +: psum_bw] = sat_add(acc[wr_pix][i*psum_bw +: psum_bw],
                                                       fifo_dout[i*psum_bw +: psum_bw]);
            if (relu_q && drain_row[i*psum_bw + psum_bw - 1])
                drain_row[i*psum_bw +: psum_bw] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            rd_cnt    <= '0;
            wr_cnt    <= '0;
            wr_pix    <= '0;
            wr_kij    <= '0;
            drain_idx <= '0;
            rd_vld    <= 1'b0;
            relu_q    <= 1'b0;
        end else begin
            state  <= state_nxt;
            rd_vld <= fifo_rd;
            if (start_acc) begin
                rd_cnt    <= '0;
                wr_cnt    <= '0;
                wr_pix    <= '0;
                wr_kij    <= '0;
                drain_idx <= '0;
                relu_q    <= relu_en;
            end else begin
                if (fifo_rd)
                    rd_cnt <= rd_cnt + CNT_W'(1);
                if (rd_vld) begin
                    wr_cnt <= wr_cnt + CNT_W'(1);
                    if (wr_pix == addr_bw'(NPIX - 1)) begin
                        wr_pix <= '0;
                        wr_kij <= wr_kij + KIJ_W'(1);
                    end else begin
                        wr_pix <= wr_pix + addr_bw'(1);
                    end
                end
                if (drain_hs)
                    drain_idx <= last_drain ? '0 : drain_idx + addr_bw'(1);
            end
        end
    end

    // NOTE: the accumulation buffer is deliberately reset so a layer aborted mid-way
    // never leaves stale partial sums visible; this costs a reset net on every entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int p = 0; p < NPIX; p++)
                acc[p] <= '0;
        end else if (rd_vld) begin
            acc[wr_pix] <= wr_row;
        end
    end

    assign out_valid = (state == S_DRAIN);
    assign out_addr  = (state == S_DRAIN) ? drain_idx : '0;
    assign out_data  = (state == S_DRAIN) ? drain_row : '0;
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

endmodule

// File: tb/tb_psum_accumulator.sv
// Self-checking bench: directed and random layers against an integer reference model
// of saturating accumulation, ReLU and the row-drain handshake.
module tb_psum_accumulator;

    localparam int COL   = 8;
    localparam int BW    = 16;
    localparam int NPIX  = 16;
    localparam int NKIJ  = 9;
    localparam int AW    = 4;
    localparam int TOTAL = NPIX * NKIJ;
    localparam int ROW_W = COL * BW;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              relu_en = 1'b0;
    logic              fifo_rdy = 1'b0;
    logic              fifo_rd;
    logic [ROW_W-1:0]  fifo_dout = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [ROW_W-1:0]  out_data;
    logic [AW-1:0]     out_addr;
    logic              busy;
    logic              done;

    int checks   = 0;
    int failures = 0;

    // Upstream FIFO model state: stim[pop][lane] is the row returned for the pop-th read.
    logic signed [BW-1:0] stim [TOTAL][COL];
    int  exp_tab [NPIX][COL];
    int  pops = 0;
    int  pops_base = 0;
    int  rd_while_empty = 0;
    int  cyc = 0;
    int  rdy_mode = 0;
    logic [ROW_W-1:0] row0_seen;

    psum_accumulator #(
        .col(COL), .psum_bw(BW), .NPIX(NPIX), .NKIJ(NKIJ), .addr_bw(AW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .relu_en(relu_en),
        .fifo_rdy(fifo_rdy), .fifo_rd(fifo_rd), .fifo_dout(fifo_dout),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        int idx;
        if (fifo_rd) begin
            if (!fifo_rdy) rd_while_empty <= rd_while_empty + 1;
            idx = pops - pops_base;
            for (int l = 0; l < COL; l++)
                fifo_dout[l*BW +: BW] <= (idx >= 0 && idx < TOTAL) ? stim[idx][l] : '0;
            pops <= pops + 1;
        end
        case (rdy_mode)
            0:       fifo_rdy <= 1'b1;
            1:       fifo_rdy <= ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: fifo_rdy <= 1'($urandom % 2);
        endcase
        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic int clamp(input int v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Reference: pixel p of pass k is pop k*NPIX+p; pass 0 loads, later passes saturate-add.
    task automatic compute_exp();
        for (int k = 0; k < NKIJ; k++)
            for (int p = 0; p < NPIX; p++)
                for (int l = 0; l < COL; l++) begin
                    int v;
                    v = int'(stim[k*NPIX + p][l]);
                    exp_tab[p][l] = (k == 0) ? v : clamp(exp_tab[p][l] + v);
                end
    endtask

    function automatic logic [ROW_W-1:0] exp_row(input int r, input bit relu);
        logic [ROW_W-1:0] row;
        row = '0;
        for (int l = 0; l < COL; l++) begin
            int v;
            v = exp_tab[r][l];
            if (relu && v < 0) v = 0;
            row[l*BW +: BW] = 16'(v);
        end
        return row;
    endfunction

    task automatic fill_const(input logic signed [BW-1:0] v);
        for (int p = 0; p < TOTAL; p++)
            for (int l = 0; l < COL; l++)
                stim[p][l] = v;
    endtask

    task automatic fill_random();
        for (int p = 0; p < TOTAL; p++)
            for (int l = 0; l < COL; l++)
                stim[p][l] = 16'($urandom);
    endtask

    task automatic pulse_start(input bit relu);
        @(negedge clk);
        start = 1'b1;
        relu_en = relu;
        @(negedge clk);
        start = 1'b0;
        relu_en = !relu;
    endtask

    task automatic run_layer(input string name, input bit relu, input int mode,
                             input int stall_row, input bit extra_start);
        int n;
        compute_exp();
        rdy_mode  = mode;
        pops_base = pops;
        pulse_start(relu);
        check({name, "_busy_acc"}, ROW_W'(busy), ROW_W'(1));
        check({name, "_outvalid_acc"}, ROW_W'(out_valid), ROW_W'(0));
        check({name, "_outdata_acc"}, out_data, '0);
        if (extra_start) begin
            repeat (5) @(negedge clk);
            start = 1'b1;
            relu_en = !relu;
            @(negedge clk);
            start = 1'b0;
        end
        n = 0;
        while (!out_valid && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drain_timeout"}, ROW_W'(n < 3000), ROW_W'(1));
        check({name, "_pops"}, ROW_W'(pops - pops_base), ROW_W'(TOTAL));
        check({name, "_rd_while_empty"}, ROW_W'(rd_while_empty), ROW_W'(0));
        for (int r = 0; r < NPIX; r++) begin
            check($sformatf("%s_valid%0d", name, r), ROW_W'(out_valid), ROW_W'(1));
            check($sformatf("%s_addr%0d", name, r), ROW_W'(out_addr), ROW_W'(r));
            check($sformatf("%s_data%0d", name, r), out_data, exp_row(r, relu));
            if (r == 0) row0_seen = out_data;
            if (r == stall_row) begin
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check($sformatf("%s_stall_addr%0d", name, r), ROW_W'(out_addr), ROW_W'(r));
                    check($sformatf("%s_stall_data%0d", name, r), out_data, exp_row(r, relu));
                end
                out_ready = 1'b1;
            end
            @(negedge clk);
        end
        check({name, "_done_pulse"}, ROW_W'(done), ROW_W'(1));
        check({name, "_valid_after"}, ROW_W'(out_valid), ROW_W'(0));
        check({name, "_data_after"}, out_data, '0);
        @(negedge clk);
        check({name, "_done_clear"}, ROW_W'(done), ROW_W'(0));
        check({name, "_idle"}, ROW_W'(busy), ROW_W'(0));
        check({name, "_pops_final"}, ROW_W'(pops - pops_base), ROW_W'(TOTAL));
    endtask

    initial begin
        int n;
        int aborted_at;

        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_busy", ROW_W'(busy), ROW_W'(0));
        check("rst_fifo_rd", ROW_W'(fifo_rd), ROW_W'(0));
        check("rst_valid", ROW_W'(out_valid), ROW_W'(0));
        check("rst_done", ROW_W'(done), ROW_W'(0));
        check("rst_data", out_data, '0);
        check("rst_addr", ROW_W'(out_addr), ROW_W'(0));

        fill_const(16'sd1);
        run_layer("ones", 1'b0, 0, -1, 1'b0);

        fill_const(16'sd0);
        stim[0][0]    = 16'sh7000;
        stim[NPIX][0] = 16'sh7000;
        stim[0][1]    = -16'sh7000;
        stim[NPIX][1] = -16'sh7000;
        run_layer("sat", 1'b0, 0, -1, 1'b0);
        check("sat_pos_lane0", ROW_W'(row0_seen[BW-1:0]), ROW_W'(16'h7FFF));
        check("sat_neg_lane1", ROW_W'(row0_seen[2*BW-1:BW]), ROW_W'(16'h8000));

        fill_const(-16'sd2);
        run_layer("neg_norelu", 1'b0, 0, -1, 1'b0);
        check("neg_norelu_row0", ROW_W'(row0_seen[BW-1:0]), ROW_W'(16'hFFEE));
        run_layer("neg_relu", 1'b1, 0, -1, 1'b0);
        check("neg_relu_row0", ROW_W'(row0_seen[BW-1:0]), ROW_W'(16'h0000));

        fill_const(16'sd1);
        run_layer("gaps_stall", 1'b0, 1, 5, 1'b1);

        rdy_mode  = 0;
        pops_base = pops;
        pulse_start(1'b0);
        n = 0;
        while ((pops - pops_base) < 40 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("abort_reach40", ROW_W'(pops - pops_base), ROW_W'(40));
        reset = 1'b1;
        aborted_at = pops;
        @(negedge clk);
        check("abort_busy", ROW_W'(busy), ROW_W'(0));
        check("abort_fifo_rd", ROW_W'(fifo_rd), ROW_W'(0));
        check("abort_valid", ROW_W'(out_valid), ROW_W'(0));
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_no_pop", ROW_W'(pops - aborted_at), ROW_W'(0));
        run_layer("after_abort", 1'b0, 0, -1, 1'b1);

        fill_random();
        run_layer("rand_a", 1'b0, 2, 3, 1'b0);
        fill_random();
        run_layer("rand_b", 1'b1, 2, 11, 1'b1);
        for (int p = 0; p < TOTAL; p++)
            for (int l = 0; l < COL; l++)
                stim[p][l] = 16'($signed(($urandom % 2001)) - 1000);
        run_layer("rand_small", 1'($urandom % 2), 2, -1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/psum_accumulator.md
Name: psum_accumulator

Overview:
- Sits directly downstream of the compressed output FIFO at the bottom of the 2D systolic array.
- Pops one decompressed row of col psums per read and accumulates across all kernel positions (kij) of a conv layer into an internal buffer.
- After the last kij pass, applies optional ReLU and drains one result row per handshake toward the activation SRAM writeback path.

Parameters:
- col, 8, number of array columns (psum lanes per row)
- psum_bw, 16, signed psum width per lane
- NPIX, 16, output pixels (rows) per kij pass
- NKIJ, 9, kernel positions accumulated per output
- addr_bw, 4, width of pixel index; must satisfy 2^addr_bw >= NPIX

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; begins a layer when IDLE
- relu_en  in  1  sampled on accepted start; enables ReLU on drain
- fifo_rdy  in  1  upstream FIFO holds at least one row
- fifo_rd  out  1  pop request to upstream FIFO
- fifo_dout  in  col*psum_bw  row data; valid the cycle after fifo_rd
- out_valid  out  1  drain row valid
- out_ready  in  1  downstream accepts row
- out_data  out  col*psum_bw  accumulated, optionally ReLU'd row
- out_addr  out  addr_bw  pixel index of out_data
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at end of drain

Behaviour:
- Reset: reset, synchronous, active-high; clock clk.
  - State goes to IDLE; all counters 0; acc buffer cleared to 0.
  - fifo_rd, out_valid, busy, done, out_data, out_addr all read 0.
  - A reset mid-operation aborts immediately; no further fifo_rd is issued, including a pending in-flight read.
- FSM states: IDLE, ACC, DRAIN, DONE.
  - IDLE -> ACC on start. relu_en is latched into relu_q at that edge.
  - start in any other state is ignored.
  - ACC -> DRAIN when the write-side count reaches NPIX*NKIJ.
  - DRAIN -> DONE on handshake of row NPIX-1.
  - DONE -> IDLE after exactly one cycle, with done=1 during that cycle.
- ACC read side:
  - fifo_rd = (state==ACC) && fifo_rdy && (rd_cnt < NPIX*NKIJ), registered-free (combinational).
  - Back-to-back reads are allowed (one per cycle).
  - fifo_rd is never high while fifo_rdy=0.
  - rd_cnt increments on each fifo_rd.
- ACC write side:
  - rd_vld is fifo_rd delayed one cycle.
  - On rd_vld, fifo_dout is applied to acc[wr_pix].
  - If wr_kij==0, acc[wr_pix] is overwritten with fifo_dout.
  - Otherwise acc[wr_pix] = sat_add(acc[wr_pix], fifo_dout), per lane.
  - wr_pix wraps NPIX-1 -> 0 and increments wr_kij on wrap.
  - Latency from fifo_rd to acc update is 1 cycle; throughput is 1 row/cycle.
- Arithmetic: per lane, signed psum_bw two's complement, saturating.
  - Positive overflow clamps to +2^(psum_bw-1)-1 (0x7FFF).
  - Negative overflow clamps to -2^(psum_bw-1) (0x8000).
  - Lane i occupies bits [i*psum_bw +: psum_bw].
- DRAIN:
  - out_valid=1 and out_addr=drain_idx.
  - out_data = acc[drain_idx], with each negative lane forced to 0 when relu_q=1.
  - drain_idx advances only on out_valid && out_ready.
  - out_data and out_addr are held stable while out_ready=0.
  - out_valid drops to 0 the cycle after the last handshake.
- Boundaries:
  - fifo_rdy gaps stall reads only; accumulation results are independent of read timing.
  - The final read's data is still accumulated before entering DRAIN.
  - Outside DRAIN, out_valid=0 and out_data=0.

Test Plan:
- Every row is all lanes = 1, for 9 passes, relu_en=0 -> 16 drained rows, each lane = 9 (0x0009), out_addr 0..15 in order, then done pulses once.
- Lane 0 row 0: pass 0 = 0x7000, pass 1 = 0x7000, remaining passes 0 -> out row 0 lane 0 = 0x7FFF. Same with 0x9000 + 0x9000 -> 0x8000.
- Each row all lanes = -2 (0xFFFE), 9 passes -> relu_en=0 gives 0xFFEE (-18); relu_en=1 gives 0x0000.
- fifo_rdy toggles 1,0,0,1 repeatedly in scenario 1 -> identical results; fifo_rd never asserted while fifo_rdy=0; exactly 144 pops total.
- out_ready held low 3 cycles at drain row 5 -> out_addr stays 5 and out_data unchanged; row 5 is accepted once, with no skipped or duplicated rows.
- reset asserted after 40 pops -> next cycle busy=0 and fifo_rd=0. A new start then runs scenario 1 cleanly to all-9 results; start pulses during ACC are ignored.
